// File: rtl/cnt6_down.sv
// cnt6_down -- six-bit countdown timer (0..59 seconds).
//
// Loads a seconds value, then decrements it once per tick period of
// max(num,1) clk cycles until it reaches zero, where it flags completion.
// Ticks come from an internal single-cycle enable, so everything runs in
// the clk domain.
//
// Optional feature macro: CNT6_DOWN_AUTO_RELOAD_EN
//   defined   : on reaching zero reload the last loaded value and keep
//               running; done pulses for one cycle per reload.
//   undefined : stop in DONE with done held high until the next load.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   num      in   [31:0] tick period in clk cycles (0 and 1 mean 1)
//   load_val in   [5:0]  value to load, saturated to 59
//   load     in   load strobe
//   start    in   start/resume strobe
//   pause    in   pause strobe
//   out      out  [5:0]  current count (registered)
//   running  out  high while counting (registered)
//   done     out  completion flag (registered)
module cnt6_down (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] num,
  input  logic [5:0]  load_val,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  output logic [5:0]  out,
  output logic        running,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  out_q, out_d;
  logic [5:0]  last_q, last_d;        // last loaded value, used for reload
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;

  logic [31:0] tick_max;
  logic [5:0]  load_sat;
  logic        tick;

  // Terminal count of the tick counter; num of 0 or 1 both give a tick every cycle.
  assign tick_max = (num > 32'd1) ? (num - 32'd1) : 32'd0;
  // Loaded values above 59 saturate.
  assign load_sat = (load_val > 6'd59) ? 6'd59 : load_val;
  // Tick enable only exists while counting.
  assign tick     = (state_q == ST_RUN) && (tick_cnt_q == tick_max);

  // Next-state, count and flag logic.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    last_d     = last_q;
    tick_cnt_d = tick_cnt_q;
`ifdef CNT6_DOWN_AUTO_RELOAD_EN
    done_d     = 1'b0;                // done is a one-cycle pulse
`else
    done_d     = done_q;              // done holds until the next load
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          out_d      = load_sat;
          last_d     = load_sat;
          tick_cnt_d = 32'd0;
        end else if (start && (out_q != 6'd0)) begin
          state_d    = ST_RUN;
          tick_cnt_d = 32'd0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        // load/start are ignored here; pause wins over a coincident tick
        // and the counter holds so the partial period survives the pause.
        if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          tick_cnt_d = 32'd0;
          if (out_q <= 6'd1) begin
`ifdef CNT6_DOWN_AUTO_RELOAD_EN
            out_d   = last_q;
            done_d  = 1'b1;
`else
            out_d   = 6'd0;
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            out_d   = out_q - 6'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 32'd1;
        end
      end
      ST_PAUSE: begin
        if (load) begin
          state_d    = ST_IDLE;
          out_d      = load_sat;
          last_d     = load_sat;
          tick_cnt_d = 32'd0;
        end else if (start) begin
          state_d    = ST_RUN;
        end else begin
          state_d    = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (load) begin
          state_d    = ST_IDLE;
          out_d      = load_sat;
          last_d     = load_sat;
          done_d     = 1'b0;
          tick_cnt_d = 32'd0;
        end else begin
          out_d      = 6'd0;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        out_d      = 6'd0;
        done_d     = 1'b0;
        tick_cnt_d = 32'd0;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_q      <= 6'd0;
      last_q     <= 6'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      tick_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      last_q     <= last_d;
      running_q  <= running_d;
      done_q     <= done_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign out     = out_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
